// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style controller.
// A Moore FSM steps each instruction through fetch, decode and execute phases,
// waiting on memready for every memory access, and drives the datapath
// selects, write enables and ALU operation for the current step.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  state_t     r_state;
  state_t     w_next_state;

  logic       w_iord;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_pcsrc;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_regwrite;
  logic       w_regdst;
  logic       w_memtoreg;
  logic [1:0] w_aluop;
  logic       w_alu_active;

  // ALU decoder: the FSM picks add/sub directly, or defers to funct for R-type.
  function automatic logic [2:0] alu_decode(input logic [1:0] aluop, input logic [5:0] fn);
    logic [2:0] ctl;
    ctl = 3'b010;
    case (aluop)
      ALUOP_ADD: ctl = 3'b010;
      ALUOP_SUB: ctl = 3'b110;
      ALUOP_FUNCT: begin
        case (fn)
          6'b100000: ctl = 3'b010;
          6'b100010: ctl = 3'b110;
          6'b100100: ctl = 3'b000;
          6'b100101: ctl = 3'b001;
          6'b101010: ctl = 3'b111;
          default:   ctl = 3'b010;
        endcase
      end
      default: ctl = 3'b010;
    endcase
    return ctl;
  endfunction

  // State register; reset overrides any pending memory wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; unused codes fall back to FETCH.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH: begin
        if (memready) begin
          w_next_state = S_DECODE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXECUTE;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEXEC;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          w_next_state = S_MEMRD;
        end else begin
          w_next_state = S_MEMWR;
        end
      end
      S_MEMRD: begin
        if (memready) begin
          w_next_state = S_MEMWB;
        end else begin
          w_next_state = S_MEMRD;
        end
      end
      S_MEMWR: begin
        if (memready) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_MEMWR;
        end
      end
      S_EXECUTE:  w_next_state = S_ALUWB;
      S_ADDIEXEC: w_next_state = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: w_next_state = S_FETCH;
      default:    w_next_state = S_FETCH;
    endcase
  end

  // Moore output decode; FETCH's load enables follow memready so the
  // instruction and PC update only on the cycle the read completes.
  always_comb begin
    w_iord       = 1'b0;
    w_irwrite    = 1'b0;
    w_memwrite   = 1'b0;
    w_alusrca    = 1'b0;
    w_alusrcb    = 2'b00;
    w_pcsrc      = 2'b00;
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;
    w_regwrite   = 1'b0;
    w_regdst     = 1'b0;
    w_memtoreg   = 1'b0;
    w_aluop      = ALUOP_ADD;
    w_alu_active = 1'b1;
    case (r_state)
      S_FETCH: begin
        w_alusrcb = 2'b01;
        w_irwrite = memready;
        w_pcwrite = memready;
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
      end
      S_MEMADR, S_ADDIEXEC: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_regdst   = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_SUB;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
      end
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: begin
        // Unused codes drive every output low, ALU control included.
        w_alu_active = 1'b0;
      end
    endcase
  end

  // Write enables are suppressed while reset is held; selects follow the state.
  assign iord       = w_iord;
  assign irwrite    = w_irwrite & ~reset;
  assign memwrite   = w_memwrite & ~reset;
  assign alusrca    = w_alusrca;
  assign alusrcb    = w_alusrcb;
  assign pcsrc      = w_pcsrc;
  assign pcen       = (w_pcwrite | (w_branch & zero)) & ~reset;
  assign regwrite   = w_regwrite & ~reset;
  assign regdst     = w_regdst;
  assign memtoreg   = w_memtoreg;
  assign alucontrol = w_alu_active ? alu_decode(w_aluop, funct) : 3'b000;
  assign state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each directed step pushes the
// hand-derived expected state and outputs; a negedge monitor pops and compares.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       iord, irwrite, memwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen, regwrite, regdst, memtoreg;
  logic [2:0] alucontrol;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] outs;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memready(memready), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alucontrol(alucontrol), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for a given state, packed as
  // {iord, irwrite, memwrite, alusrca, alusrcb, pcsrc, pcen, regwrite, regdst, memtoreg, alucontrol}.
  function automatic logic [14:0] exp_out(input logic [3:0] st, input logic mr,
                                          input logic z, input logic [5:0] fn,
                                          input logic rst);
    logic       e_iord, e_irw, e_mw, e_asa, e_pce, e_rw, e_rd, e_mtr;
    logic [1:0] e_asb, e_ps;
    logic [2:0] e_ac;
    {e_iord, e_irw, e_mw, e_asa, e_pce, e_rw, e_rd, e_mtr} = 8'b0;
    e_asb = 2'b00;
    e_ps  = 2'b00;
    e_ac  = 3'b010;
    case (st)
      4'd0:       begin e_asb = 2'b01; e_irw = mr; e_pce = mr; end
      4'd1:       e_asb = 2'b11;
      4'd2, 4'd9: begin e_asa = 1'b1; e_asb = 2'b10; end
      4'd3:       e_iord = 1'b1;
      4'd4:       begin e_rw = 1'b1; e_mtr = 1'b1; end
      4'd5:       begin e_iord = 1'b1; e_mw = 1'b1; end
      4'd6: begin
        e_asa = 1'b1;
        case (fn)
          6'b100010: e_ac = 3'b110;
          6'b100100: e_ac = 3'b000;
          6'b100101: e_ac = 3'b001;
          6'b101010: e_ac = 3'b111;
          default:   e_ac = 3'b010;
        endcase
      end
      4'd7:       begin e_rw = 1'b1; e_rd = 1'b1; end
      4'd8:       begin e_asa = 1'b1; e_ps = 2'b01; e_ac = 3'b110; e_pce = z; end
      4'd10:      e_rw = 1'b1;
      4'd11:      begin e_ps = 2'b10; e_pce = 1'b1; end
      default:    e_ac = 3'b000;
    endcase
    if (rst) begin
      e_irw = 1'b0;
      e_mw  = 1'b0;
      e_rw  = 1'b0;
      e_pce = 1'b0;
    end
    return {e_iord, e_irw, e_mw, e_asa, e_asb, e_ps, e_pce, e_rw, e_rd, e_mtr, e_ac};
  endfunction

  // One cycle of stimulus: drive inputs after the edge and queue the expectation
  // for the state the DUT should be in during this cycle.
  task automatic step(input logic rst, input logic [5:0] o, input logic [5:0] fn,
                      input logic z, input logic mr, input logic [3:0] exp_st);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rst;
    op       = o;
    funct    = fn;
    zero     = z;
    memready = mr;
    e.st     = exp_st;
    e.outs   = exp_out(exp_st, mr, z, fn, rst);
    q.push_back(e);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [14:0] act;
      e   = q.pop_front();
      act = {iord, irwrite, memwrite, alusrca, alusrcb, pcsrc, pcen,
             regwrite, regdst, memtoreg, alucontrol};
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL state: got %0d expected %0d at %0t", state, e.st, $time);
      end
      checks++;
      if (act !== e.outs) begin
        errors++;
        $display("FAIL outputs in state %0d: got %b expected %b at %0t",
                 e.st, act, e.outs, $time);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    op       = 6'b000000;
    funct    = 6'b000000;
    zero     = 1'b0;
    memready = 1'b0;

    // Reset held: state FETCH, write enables forced low despite memready.
    step(1'b1, RT, 6'd0, 1'b0, 1'b1, 4'd0);
    // lw with memready high: 0,1,2,3,4.
    step(1'b0, LW, 6'd0, 1'b0, 1'b1, 4'd0);
    step(1'b0, LW, 6'd0, 1'b0, 1'b1, 4'd1);
    step(1'b0, LW, 6'd0, 1'b0, 1'b1, 4'd2);
    step(1'b0, LW, 6'd0, 1'b0, 1'b1, 4'd3);
    step(1'b0, LW, 6'd0, 1'b0, 1'b1, 4'd4);
    // Fetch stall two cycles, then R-type slt: 0,0,0,1,6,7.
    step(1'b0, RT, 6'b101010, 1'b0, 1'b0, 4'd0);
    step(1'b0, RT, 6'b101010, 1'b0, 1'b0, 4'd0);
    step(1'b0, RT, 6'b101010, 1'b0, 1'b1, 4'd0);
    step(1'b0, RT, 6'b101010, 1'b0, 1'b1, 4'd1);
    step(1'b0, RT, 6'b101010, 1'b0, 1'b1, 4'd6);
    step(1'b0, RT, 6'b101010, 1'b0, 1'b1, 4'd7);
    // R-type and / sub.
    step(1'b0, RT, 6'b100100, 1'b0, 1'b1, 4'd0);
    step(1'b0, RT, 6'b100100, 1'b0, 1'b1, 4'd1);
    step(1'b0, RT, 6'b100100, 1'b0, 1'b1, 4'd6);
    step(1'b0, RT, 6'b100100, 1'b0, 1'b1, 4'd7);
    step(1'b0, RT, 6'b100010, 1'b0, 1'b1, 4'd0);
    step(1'b0, RT, 6'b100010, 1'b0, 1'b1, 4'd1);
    step(1'b0, RT, 6'b100010, 1'b0, 1'b1, 4'd6);
    step(1'b0, RT, 6'b100010, 1'b0, 1'b1, 4'd7);
    // beq taken then not taken.
    step(1'b0, BEQ, 6'd0, 1'b1, 1'b1, 4'd0);
    step(1'b0, BEQ, 6'd0, 1'b1, 1'b1, 4'd1);
    step(1'b0, BEQ, 6'd0, 1'b1, 1'b1, 4'd8);
    step(1'b0, BEQ, 6'd0, 1'b0, 1'b1, 4'd0);
    step(1'b0, BEQ, 6'd0, 1'b0, 1'b1, 4'd1);
    step(1'b0, BEQ, 6'd0, 1'b0, 1'b1, 4'd8);
    // addi: 0,1,9,10.
    step(1'b0, ADDI, 6'd0, 1'b0, 1'b1, 4'd0);
    step(1'b0, ADDI, 6'd0, 1'b0, 1'b1, 4'd1);
    step(1'b0, ADDI, 6'd0, 1'b0, 1'b1, 4'd9);
    step(1'b0, ADDI, 6'd0, 1'b0, 1'b1, 4'd10);
    // j: 0,1,11.
    step(1'b0, JMP, 6'd0, 1'b0, 1'b1, 4'd0);
    step(1'b0, JMP, 6'd0, 1'b0, 1'b1, 4'd1);
    step(1'b0, JMP, 6'd0, 1'b0, 1'b1, 4'd11);
    // Undefined opcode: DECODE returns straight to FETCH.
    step(1'b0, BAD, 6'b101010, 1'b0, 1'b1, 4'd0);
    step(1'b0, BAD, 6'b101010, 1'b0, 1'b1, 4'd1);
    // lw with a one-cycle read wait in MEMRD.
    step(1'b0, LW, 6'd0, 1'b0, 1'b1, 4'd0);
    step(1'b0, LW, 6'd0, 1'b0, 1'b1, 4'd1);
    step(1'b0, LW, 6'd0, 1'b0, 1'b1, 4'd2);
    step(1'b0, LW, 6'd0, 1'b0, 1'b0, 4'd3);
    step(1'b0, LW, 6'd0, 1'b0, 1'b1, 4'd3);
    step(1'b0, LW, 6'd0, 1'b0, 1'b1, 4'd4);
    // sw with a one-cycle write wait.
    step(1'b0, SW, 6'd0, 1'b0, 1'b1, 4'd0);
    step(1'b0, SW, 6'd0, 1'b0, 1'b1, 4'd1);
    step(1'b0, SW, 6'd0, 1'b0, 1'b1, 4'd2);
    step(1'b0, SW, 6'd0, 1'b0, 1'b0, 4'd5);
    step(1'b0, SW, 6'd0, 1'b0, 1'b1, 4'd5);
    // sw stalled in MEMWR, reset asserted mid-wait.
    step(1'b0, SW, 6'd0, 1'b0, 1'b1, 4'd0);
    step(1'b0, SW, 6'd0, 1'b0, 1'b1, 4'd1);
    step(1'b0, SW, 6'd0, 1'b0, 1'b1, 4'd2);
    step(1'b0, SW, 6'd0, 1'b0, 1'b0, 4'd5);
    step(1'b0, SW, 6'd0, 1'b0, 1'b0, 4'd5);
    step(1'b1, SW, 6'd0, 1'b0, 1'b0, 4'd5);
    step(1'b0, RT, 6'd0, 1'b0, 1'b0, 4'd0);
    step(1'b0, RT, 6'd0, 1'b0, 1'b0, 4'd0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 4 && q.size() > 0; i++) begin
      @(posedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
